// File: rtl/dm_access_stage.sv
// Data-memory access stage: turns EX/DM load/store control into a req/ack memory transaction,
// stalls the pipeline until completion and formats load data. Optional macro: DM_TIMEOUT_EN.
module dm_access_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [4:0]  rd_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] read_data,
    output logic [4:0]  rd_out,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic        dm_stall,
    output logic        misalign_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_next;
    logic        access, misaligned, start, is_store, timeout;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [1:0]  ld_size;
    logic        ld_uns;
    logic [1:0]  ld_lane;
    logic        ld_is_load;

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    function automatic logic [31:0] format_load(input logic [31:0] w, input logic [1:0] sz,
                                                input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = 8'h00;
        h   = 16'h0000;
        res = w;
        case (sz)
            2'b00: begin
                case (lane)
                    2'd0:    b = w[7:0];
                    2'd1:    b = w[15:8];
                    2'd2:    b = w[23:16];
                    default: b = w[31:24];
                endcase
                res = {{24{~uns & b[7]}}, b};
            end
            2'b01: begin
                h   = lane[1] ? w[31:16] : w[15:0];
                res = {{16{~uns & h[15]}}, h};
            end
            default: res = w;
        endcase
        return res;
    endfunction

    assign access       = mem_read | mem_write;
    assign is_store     = mem_write & ~mem_read;
    assign misalign_err = access & misaligned;
    assign start        = access & ~misaligned;

    // NOTE: every variable assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = write_data;
        case (mem_size)
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{write_data[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{write_data[15:0]}};
            end
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

`ifdef DM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    assign timeout = (state == REQ) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            wait_cnt <= (state == REQ && state_next == REQ) ? wait_cnt + 1'b1 : '0;
            bus_err  <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (mem_ack || timeout) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state == REQ);
        dm_stall = (state == REQ) || (state == IDLE && start);
    end

    // Request fields are frozen at issue so the bus stays stable while the request is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            read_data  <= '0;
            ld_size    <= '0;
            ld_uns     <= 1'b0;
            ld_lane    <= '0;
            ld_is_load <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                mem_we     <= is_store;
                mem_addr   <= {addr[31:2], 2'b00};
                mem_be     <= be_calc;
                mem_wdata  <= wdata_calc;
                ld_size    <= mem_size;
                ld_uns     <= mem_unsigned;
                ld_lane    <= addr[1:0];
                ld_is_load <= ~is_store;
            end
            if (state == REQ) begin
                if (mem_ack) begin
                    if (ld_is_load) read_data <= format_load(mem_rdata, ld_size, ld_uns, ld_lane);
                end else if (timeout) begin
                    read_data <= '0;
                end
            end
        end
    end

    assign rd_out         = rd_in;
    assign mem_to_reg_out = mem_to_reg_in;
    assign reg_write_out  = reg_write_in & ~misalign_err & ~bus_err;

endmodule

// File: tb/tb_dm_access_stage.sv
// Scoreboard bench for dm_access_stage: directed load/store vectors, responses checked by a monitor.
module tb_dm_access_stage;

`ifdef DM_TIMEOUT_EN
    localparam int TO_CYCLES = 4;
`else
    localparam int TO_CYCLES = 255;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, mem_unsigned, mem_to_reg_in, reg_write_in;
    logic [1:0]  mem_size;
    logic [31:0] addr, write_data, mem_rdata;
    logic [4:0]  rd_in;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_to_reg_out, reg_write_out, dm_stall, misalign_err, bus_err;
    logic [31:0] mem_addr, mem_wdata, read_data;
    logic [3:0]  mem_be;
    logic [4:0]  rd_out;

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t sb[$];
    bit    prev_stall = 1'b0;

    dm_access_stage #(.TIMEOUT_CYCLES(TO_CYCLES), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr), .write_data(write_data),
        .rd_in(rd_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .read_data(read_data),
        .rd_out(rd_out), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .dm_stall(dm_stall), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        check(nm, 32'(act), 32'(exp));
    endtask

    task automatic set_nop();
        mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
        addr = '0; write_data = '0; rd_in = '0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0;
    endtask

    // Response monitor: a stall that drops outside reset marks the RESP cycle.
    always @(negedge clk) begin
        resp_t r;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !dm_stall) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    r = sb.pop_front();
                    check("resp_read_data", read_data, r.data);
                    check("resp_rd_out", 32'(rd_out), 32'(r.rd));
                    check1("resp_reg_write", reg_write_out, r.rw);
                    check1("resp_mem_to_reg", mem_to_reg_out, r.m2r);
                end
            end
            prev_stall = dm_stall;
        end
    end

    // Issues one aligned access (called at posedge+1 with the FSM idle) and plays the memory side.
    task automatic mem_op(input string nm, input logic rd_en, input logic wr_en,
                          input logic [1:0] sz, input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rdi, input int ack_at,
                          input logic [31:0] rdata, input logic exp_we, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_data);
        resp_t r;
        int    stall_n;
        int    req_n;
        bit    done;
        mem_read = rd_en; mem_write = wr_en; mem_size = sz; mem_unsigned = uns;
        addr = a; write_data = wd; rd_in = rdi; reg_write_in = rd_en; mem_to_reg_in = rd_en;
        r.data = exp_data; r.rd = rdi; r.rw = rd_en; r.m2r = rd_en;
        sb.push_back(r);
        @(negedge clk);
        check1({nm, "_idle_stall"}, dm_stall, 1'b1);
        stall_n = int'(dm_stall);
        @(posedge clk); #1;
        req_n = 0;
        done  = 1'b0;
        while (!done && req_n < 64) begin
            @(negedge clk);
            if (req_n == 0) begin
                check1({nm, "_req"}, mem_req, 1'b1);
                check1({nm, "_we"}, mem_we, exp_we);
                check({nm, "_addr"}, mem_addr, {a[31:2], 2'b00});
                check({nm, "_be"}, 32'(mem_be), 32'(exp_be));
                check({nm, "_wdata"}, mem_wdata, exp_wdata);
            end
            req_n++;
            stall_n += int'(dm_stall);
            if (req_n == ack_at) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
                done = 1'b1;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        if (!done) check({nm, "_ack_wait_expired"}, 32'd0, 32'd1);
        check({nm, "_stall_cycles"}, 32'(stall_n), 32'(ack_at + 1));
        @(posedge clk); #1;
        set_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_n;
        int be_n;
        bit seen;
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        set_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check1("rst_bus_err", bus_err, 1'b0);
        check1("rst_stall", dm_stall, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        mem_op("ld_word", 1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF,
               0, 4'b1111, 32'h0, 32'hDEADBEEF);
        mem_op("ld_byte_s", 1, 0, 2'b00, 0, 32'h203, 32'h0, 5'd6, 1, 32'h80FF1234,
               0, 4'b1000, 32'h0, 32'hFFFFFF80);
        mem_op("ld_byte_u", 1, 0, 2'b00, 1, 32'h203, 32'h0, 5'd6, 2, 32'h80FF1234,
               0, 4'b1000, 32'h0, 32'h00000080);
        mem_op("st_half", 0, 1, 2'b01, 0, 32'h42, 32'h0000ABCD, 5'd0, 1, 32'hFFFFFFFF,
               1, 4'b1100, 32'hABCDABCD, 32'h00000080);
        mem_op("st_byte", 0, 1, 2'b00, 0, 32'h201, 32'h12345678, 5'd0, 2, 32'hFFFFFFFF,
               1, 4'b0010, 32'h78787878, 32'h00000080);
        mem_op("ld_half_s", 1, 0, 2'b01, 0, 32'h6, 32'h0, 5'd7, 1, 32'h80017FFF,
               0, 4'b1100, 32'h0, 32'hFFFF8001);
        mem_op("ld_size11", 1, 0, 2'b11, 0, 32'h8, 32'h0, 5'd8, 2, 32'hCAFEF00D,
               0, 4'b1111, 32'h0, 32'hCAFEF00D);
        mem_op("ld_and_st", 1, 1, 2'b10, 0, 32'hC, 32'h55AA55AA, 5'd3, 1, 32'h12345678,
               0, 4'b1111, 32'h55AA55AA, 32'h12345678);

        // Misaligned word and half: flagged, no request, no stall, write-back suppressed.
        mem_read = 1'b1; mem_size = 2'b10; addr = 32'h101; rd_in = 5'd4;
        reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
        @(negedge clk);
        check1("mis_word_err", misalign_err, 1'b1);
        check1("mis_word_stall", dm_stall, 1'b0);
        check1("mis_word_rw", reg_write_out, 1'b0);
        @(posedge clk); #1;
        mem_size = 2'b01; addr = 32'h43;
        @(negedge clk);
        check1("mis_half_err", misalign_err, 1'b1);
        check1("mis_half_req", mem_req, 1'b0);
        @(posedge clk); #1;

        // Non-memory op with a stray ack: passthrough, read_data held.
        set_nop();
        rd_in = 5'd17; reg_write_in = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("nop_rd_out", 32'(rd_out), 32'd17);
        check1("nop_rw", reg_write_out, 1'b1);
        check1("nop_stall", dm_stall, 1'b0);
        check1("nop_mis", misalign_err, 1'b0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check1("nop_no_req", mem_req, 1'b0);
        check("nop_hold_data", read_data, 32'h12345678);
        @(posedge clk); #1;

        // Reset during REQ, then a late ack after release.
        mem_read = 1'b1; mem_size = 2'b10; addr = 32'h300; rd_in = 5'd9;
        reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check1("rstreq_req_before", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        set_nop();
        #1;
        check1("rstreq_req_dropped", mem_req, 1'b0);
        check("rstreq_read_data", read_data, 32'h0);
        @(negedge clk); #2;
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("rstreq_late_ack_data", read_data, 32'h0);
        check1("rstreq_late_ack_req", mem_req, 1'b0);
        check("rstreq_be", 32'(mem_be), 32'h0);
        @(posedge clk); #1;

`ifdef DM_TIMEOUT_EN
        begin
            resp_t r;
            mem_read = 1'b1; mem_size = 2'b10; addr = 32'h500; rd_in = 5'd10;
            reg_write_in = 1'b1; mem_to_reg_in = 1'b1;
            r.data = 32'h0; r.rd = 5'd10; r.rw = 1'b0; r.m2r = 1'b1;
            sb.push_back(r);
            req_n = 0; be_n = 0; seen = 1'b0;
            for (int i = 0; i < 12 && !seen; i++) begin
                @(negedge clk);
                req_n += int'(mem_req);
                if (bus_err) begin
                    be_n++;
                    seen = 1'b1;
                end
            end
            @(posedge clk); #1;
            set_nop();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                be_n += int'(bus_err);
            end
            check("to_req_cycles", 32'(req_n), 32'd4);
            check("to_bus_err_pulses", 32'(be_n), 32'd1);
            check1("to_req_released", mem_req, 1'b0);
            @(posedge clk); #1;
        end
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_access_stage.md
Name: dm_access_stage

Overview:
Data-memory stage between the EX/DM and DM/WB pipeline registers. It converts load/store control from EX/DM into a req/ack transaction on a variable-latency data-memory port and stalls the pipeline until the access completes. It also aligns and sign/zero-extends load data. It presents read_data, rd, mem_to_reg and reg_write to the DM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack (used only with DM_TIMEOUT_EN)
CNT_W, 8, width of wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high
mem_read  in  1  load in DM stage
mem_write  in  1  store in DM stage (mem_read and mem_write both 1 is illegal: treated as load)
mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
addr  in  32  byte address (ALU result)
write_data  in  32  store data, low-aligned
rd_in  in  5  destination register
mem_to_reg_in, reg_write_in  in  1 each  WB control from EX/DM
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write
mem_addr  out  32  word address {addr[31:2],2'b00}
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word, valid with mem_ack
mem_ack  in  1  one-cycle completion strobe
read_data  out  32  formatted load data to DM/WB
rd_out  out  5  rd_in passthrough
mem_to_reg_out  out  1  passthrough
reg_write_out  out  1  reg_write_in & ~misalign_err & ~bus_err
dm_stall  out  1  freeze PC, IF/ID, ID/EX, EX/DM; DM/WB receives a bubble
misalign_err  out  1  combinational flag for misaligned access
bus_err  out  1  one-cycle pulse on timeout (with DM_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, read_data=0, bus_err=0, wait counter=0. Reset mid-transaction drops mem_req immediately; a late ack is ignored.
- access = mem_read|mem_write. Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Misaligned access issues no request and no stall; misalign_err=1 the same cycle.
- FSM IDLE: on aligned access, latch request fields and go to REQ. dm_stall=1 combinationally this cycle.
- FSM REQ: mem_req=1, dm_stall=1. On mem_ack, capture formatted mem_rdata (loads only; stores leave read_data unchanged) and go to RESP. An ack in the first REQ cycle is valid. Minimum access latency is 2 cycles of stall.
- FSM RESP: dm_stall=0, mem_req=0, inputs ignored. Go to IDLE next cycle. At this edge DM/WB captures the result and EX/DM advances.
- mem_ack outside REQ is ignored.
- Store lanes:
  - byte: be = 0001<<addr[1:0], wdata = {4{wd[7:0]}}
  - half: be = 0011 or 1100 by addr[1], wdata = {2{wd[15:0]}}
  - word: be = 1111, wdata = wd
- Load extract (little-endian): byte lane = addr[1:0], half lane = addr[1]. Extend per mem_unsigned. Word is passed through unchanged.
- Non-memory instructions: zero-cycle passthrough of control, no stall, read_data holds its last value.

Optional Feature:
DM_TIMEOUT_EN:
- Defined: the wait counter increments in REQ and clears on leaving REQ. When the counter reaches TIMEOUT_CYCLES without ack, drop mem_req, pulse bus_err for 1 cycle, set read_data=0 and go to RESP. reg_write_out is suppressed during that RESP cycle.
- Undefined: no counter, REQ waits indefinitely, bus_err tied 0.

Test Plan:
- Word load, addr=0x100, ack 3 cycles after req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, dm_stall high 4 cycles, read_data=0xDEADBEEF in RESP, reg_write_out=1.
- Signed byte load, addr=0x203, mem_rdata=0x80FF1234, mem_unsigned=0 -> read_data=0xFFFFFF80. Same with mem_unsigned=1 -> 0x00000080.
- Half store, addr=0x42, write_data=0x0000ABCD, ack in first REQ cycle -> mem_we=1, be=1100, wdata=0xABCDABCD, stall exactly 2 cycles.
- Word load, addr=0x101 -> misalign_err=1, mem_req never asserted, dm_stall=0, reg_write_out=0.
- Reset asserted during REQ, ack arrives 1 cycle later -> mem_req=0 immediately, state IDLE, read_data=0, late ack ignored.
- DM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> after 4 REQ cycles bus_err pulses once, read_data=0, reg_write_out=0, stall released.
